// File: rtl/nios_core_nios2_cpu_cpu_debug_mon_mem.sv
// Debug monitor RAM (256x32) shared by JTAG command pulses and a CPU slave port; define MON_MEM_JTAG_AUTOINC_EN to step MonAReg after every JTAG RAM access.
// CPU write 1 cycle, CPU read 2 cycles (waitrequest high in the accept cycle), JTAG read lands in MonDReg 2 cycles after its pulse; JTAG work wins and stalls the CPU.
module nios_core_nios2_cpu_cpu_debug_mon_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [8:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        debugaccess,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CRD = 2'd1, ST_JRD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        pend_a_q, pend_a_d;
  logic        pend_b_q, pend_b_d;
  logic        pend_n_q, pend_n_d;
  logic [8:0]  jdo_a_q, jdo_a_d;   // {clear flags, address}
  logic [31:0] jdo_b_q, jdo_b_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic [31:0] readdata_q, readdata_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        reg_sel_q, reg_sel_d;

  logic [8:0]  cmd_a;
  logic [31:0] cmd_b;
  logic        idle, jtag_busy, svc_a, svc_b, svc_n;
  logic        cpu_wr, cpu_rd, reg_wr, flag_clr;
  logic        ram_we, ram_re;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, crd_data;
  logic [31:0] mem [256];

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // A queued pulse stays queued until serviced; a new pulse re-arms it once the old one drains.
  function automatic logic next_pend(input logic pend, input logic pulse, input logic svc);
    return pend ? (~svc | pulse) : (pulse & ~svc);
  endfunction

  always_comb begin
    cmd_a     = pend_a_q ? jdo_a_q : jdo[34:26];
    cmd_b     = pend_b_q ? jdo_b_q : jdo[34:3];
    idle      = (state_q == ST_IDLE);
    jtag_busy = pend_a_q | take_action_ocimem_a | pend_b_q | take_action_ocimem_b
              | pend_n_q | take_no_action_ocimem_a;
    svc_a     = idle & (pend_a_q | take_action_ocimem_a);
    svc_b     = idle & (pend_b_q | take_action_ocimem_b) & ~svc_a;
    svc_n     = idle & (pend_n_q | take_no_action_ocimem_a) & ~svc_a & ~svc_b;
    cpu_wr    = idle & ~jtag_busy & write;
    cpu_rd    = idle & ~jtag_busy & read & ~write;
    reg_wr    = cpu_wr & debugaccess & address[8];
    flag_clr  = svc_a & cmd_a[8];
  end

  always_comb begin
    ram_we    = ~reset & (svc_b | (cpu_wr & debugaccess & ~address[8]));
    ram_re    = svc_n | (cpu_rd & ~address[8]);
    ram_addr  = (svc_b | svc_n) ? mon_a_q : address[7:0];
    ram_be    = svc_b ? 4'hF : byteenable;
    ram_wdata = svc_b ? cmd_b : writedata;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  always_comb begin
    pend_a_d  = next_pend(pend_a_q, take_action_ocimem_a, svc_a);
    pend_b_d  = next_pend(pend_b_q, take_action_ocimem_b, svc_b);
    pend_n_d  = next_pend(pend_n_q, take_no_action_ocimem_a, svc_n);
    jdo_a_d   = (take_action_ocimem_a && (!pend_a_q || svc_a)) ? jdo[34:26] : jdo_a_q;
    jdo_b_d   = (take_action_ocimem_b && (!pend_b_q || svc_b)) ? jdo[34:3]  : jdo_b_q;
    reg_sel_d = cpu_rd ? address[8] : reg_sel_q;

    ready_d   = (ready_q & ~flag_clr) | (reg_wr & writedata[0]);
    error_d   = (error_q & ~flag_clr) | (reg_wr & writedata[1]);

    mon_a_d   = mon_a_q;
    if (svc_a) mon_a_d = cmd_a[7:0];
`ifdef MON_MEM_JTAG_AUTOINC_EN
    if (svc_b || state_q == ST_JRD) mon_a_d = mon_a_q + 8'd1;
`endif

    crd_data    = reg_sel_q ? {30'b0, error_q, ready_q} : ram_rdata;
    mon_d_d     = mon_d_q;
    readdata_d  = readdata_q;
    readdata    = readdata_q;
    state_d     = state_q;
    waitrequest = 1'b0;

    case (state_q)
      ST_IDLE: begin
        waitrequest = (read | write) & ~cpu_wr;
        if (svc_n)       state_d = ST_JRD;
        else if (cpu_rd) state_d = ST_CRD;
      end
      ST_CRD: begin
        readdata   = crd_data;
        readdata_d = crd_data;
        state_d    = ST_IDLE;
      end
      ST_JRD: begin
        waitrequest = read | write;
        mon_d_d     = ram_rdata;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    waitrequest = waitrequest & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      pend_n_q   <= 1'b0;
      mon_a_q    <= 8'd0;
      mon_d_q    <= 32'd0;
      readdata_q <= 32'd0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      pend_n_q   <= pend_n_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      readdata_q <= readdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  // Command payloads are only meaningful while their pending flag is set.
  always_ff @(posedge clk) begin
    jdo_a_q   <= jdo_a_d;
    jdo_b_q   <= jdo_b_d;
    reg_sel_q <= reg_sel_d;
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_nios_core_nios2_cpu_cpu_debug_mon_mem.sv
// Randomized and directed bench for the debug monitor RAM against an array-based model of its JTAG/CPU rules.
module tb_nios_core_nios2_cpu_cpu_debug_mon_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [8:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios_core_nios2_cpu_cpu_debug_mon_mem dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess), .readdata(readdata),
    .waitrequest(waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [256];
  logic        m_ready, m_error;
  logic [7:0]  m_a;
  logic [31:0] m_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] step(input logic [7:0] a);
`ifdef MON_MEM_JTAG_AUTOINC_EN
    return a + 8'd1;
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [8:0] a);
    return a[8] ? {30'b0, m_error, m_ready} : m_mem[a[7:0]];
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_rdy"}, 32'(monitor_ready), 32'(m_ready));
    check({tag, "_err"}, 32'(monitor_error), 32'(m_error));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    m_ready = 1'b0; m_error = 1'b0; m_a = 8'd0; m_d = 32'd0;
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic clr);
    jdo = {3'($urandom), clr, a, 26'($urandom)};
    take_action_ocimem_a = 1'b1;
    tick;
    take_action_ocimem_a = 1'b0;
    m_a = a;
    if (clr) begin m_ready = 1'b0; m_error = 1'b0; end
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = {3'($urandom), d, 3'($urandom)};
    take_action_ocimem_b = 1'b1;
    tick;
    take_action_ocimem_b = 1'b0;
    m_mem[m_a] = d;
    m_a = step(m_a);
  endtask

  task automatic jtag_rd(input string tag);
    jdo = 38'({$urandom, $urandom});
    take_no_action_ocimem_a = 1'b1;
    tick;
    take_no_action_ocimem_a = 1'b0;
    check({tag, "_early"}, MonDReg, m_d);
    tick;
    m_d = m_mem[m_a];
    m_a = step(m_a);
    check(tag, MonDReg, m_d);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, output int waits);
    address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    waits = 0;
    #2;
    while (waitrequest === 1'b1 && waits < 20) begin waits++; tick; #2; end
    if (waits >= 20) check("wr_timeout", 32'(waitrequest), 32'd0);
    tick;
    write = 1'b0; debugaccess = 1'b0;
    if (dbg) begin
      if (a[8]) begin
        if (d[0]) m_ready = 1'b1;
        if (d[1]) m_error = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic cpu_read(input logic [8:0] a, output logic [31:0] d, output int waits);
    address = a; read = 1'b1;
    waits = 0;
    #2;
    while (waitrequest === 1'b1 && waits < 20) begin waits++; tick; #2; end
    if (waits >= 20) check("rd_timeout", 32'(waitrequest), 32'd0);
    d = readdata;
    tick;
    read = 1'b0;
  endtask

  logic [31:0] v, rd, old;
  logic [37:0] jw;
  logic [8:0]  ra;
  int          w;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    do_reset;
    #2;
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_wait", 32'(waitrequest), 32'd0);
    check_flags("rst");

    for (int i = 0; i < 256; i++) begin
      cpu_write({1'b0, 8'(i)}, $urandom, 4'hF, 1'b1, w);
      if (i == 0) check("init_wr_wait", 32'(w), 32'd0);
    end

    // JTAG write then JTAG read back through MonDReg
    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    jtag_a(8'h10, 1'b0);
    jtag_rd("jtag_rd_deadbeef");
    check("deadbeef_const", MonDReg, 32'hDEADBEEF);

    // Auto-increment path (model collapses to fixed address when the feature is off)
    jtag_a(8'hFF, 1'b0);
    jtag_b(32'h1);
    jtag_b(32'h2);
    jtag_a(8'hFF, 1'b0);
    jtag_rd("autoinc_rd0");
    jtag_rd("autoinc_rd1");
    jtag_rd("autoinc_rd2");

    // CPU read held while a JTAG write to the same word wins arbitration
    jtag_a(8'h05, 1'b0);
    v = $urandom;
    address = 9'h005; read = 1'b1;
    jdo = {3'($urandom), v, 3'($urandom)};
    take_action_ocimem_b = 1'b1;
    #2; check("arb_wait0", 32'(waitrequest), 32'd1);
    tick; take_action_ocimem_b = 1'b0;
    m_mem[8'h05] = v; m_a = step(8'h05);
    #2; check("arb_wait1", 32'(waitrequest), 32'd1);
    tick;
    #2; check("arb_wait2", 32'(waitrequest), 32'd0);
    check("arb_rdata", readdata, v);
    tick; read = 1'b0;

    // Register space with and without debug privilege
    cpu_write(9'h100, 32'h3, 4'hF, 1'b1, w);
    check("reg_wr_wait", 32'(w), 32'd0);
    cpu_read(9'h100, rd, w);
    check("reg_rd_set", rd, 32'h3);
    check("reg_rd_wait", 32'(w), 32'd1);
    check_flags("reg_set");
    jtag_a(8'h00, 1'b1);
    check_flags("reg_clr");
    cpu_write(9'h100, 32'h3, 4'hF, 1'b0, w);
    check("reg_nodbg_wait", 32'(w), 32'd0);
    cpu_read(9'h1A7, rd, w);
    check("reg_rd_nodbg", rd, 32'h0);

    // JTAG read pulse arriving during CRD is queued, not dropped
    jtag_a(8'h20, 1'b0);
    jtag_b(~m_d);
    jtag_a(8'h20, 1'b0);
    address = 9'h033; read = 1'b1;
    #2; check("crd_accept_wait", 32'(waitrequest), 32'd1);
    tick;
    take_no_action_ocimem_a = 1'b1;
    #2; check("crd_wait", 32'(waitrequest), 32'd0);
    check("crd_rdata", readdata, m_mem[8'h33]);
    tick;
    take_no_action_ocimem_a = 1'b0; read = 1'b0;
    check("crd_pend_idle", MonDReg, m_d);
    tick;
    check("crd_pend_jrd", MonDReg, m_d);
    tick;
    m_d = m_mem[m_a]; m_a = step(m_a);
    check("crd_pend_done", MonDReg, m_d);

    // Reset while in JRD aborts the capture
    cpu_write(9'h1FF, 32'h3, 4'hF, 1'b1, w);
    take_no_action_ocimem_a = 1'b1;
    tick;
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_ready = 1'b0; m_error = 1'b0; m_a = 8'd0; m_d = 32'd0;
    #2;
    check("jrd_rst_mondreg", MonDReg, 32'd0);
    check("jrd_rst_readdata", readdata, 32'd0);
    check_flags("jrd_rst");
    tick; #2;
    check("jrd_rst_wait", 32'(waitrequest), 32'd0);
    jtag_rd("ram_kept");

    // CPU flag set stalled behind a JTAG flag clear; the set lands afterwards
    cpu_write(9'h1FF, 32'h2, 4'hF, 1'b1, w);
    address = 9'h100; writedata = 32'h1; byteenable = 4'hF; debugaccess = 1'b1; write = 1'b1;
    jdo = {3'($urandom), 1'b1, 8'h30, 26'($urandom)};
    take_action_ocimem_a = 1'b1;
    #2; check("lose_wait0", 32'(waitrequest), 32'd1);
    tick; take_action_ocimem_a = 1'b0;
    #2; check("lose_wait1", 32'(waitrequest), 32'd0);
    tick; write = 1'b0; debugaccess = 1'b0;
    m_a = 8'h30; m_ready = 1'b1; m_error = 1'b0;
    check_flags("lose");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: jtag_a(8'($urandom), ($urandom_range(0, 3) == 0));
        1: jtag_b($urandom);
        2: jtag_rd("rnd_jrd");
        3: begin
          ra = {($urandom_range(0, 3) == 0), 8'($urandom)};
          cpu_write(ra, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0), w);
          check("rnd_wr_wait", 32'(w), 32'd0);
        end
        4: begin
          ra = {($urandom_range(0, 3) == 0), 8'($urandom)};
          cpu_read(ra, rd, w);
          check("rnd_rd_data", rd, exp_read(ra));
          check("rnd_rd_wait", 32'(w), 32'd1);
        end
        default: begin
          jw = 38'({$urandom, $urandom});
          jdo = jw;
          take_action_ocimem_a = 1'b1;
          take_action_ocimem_b = 1'b1;
          take_no_action_ocimem_a = 1'b1;
          tick;
          take_action_ocimem_a = 1'b0;
          take_action_ocimem_b = 1'b0;
          take_no_action_ocimem_a = 1'b0;
          jdo = 38'({$urandom, $urandom});
          m_a = jw[33:26];
          if (jw[34]) begin m_ready = 1'b0; m_error = 1'b0; end
          m_mem[m_a] = jw[34:3];
          m_a = step(m_a);
          old = m_d;
          m_d = m_mem[m_a];
          m_a = step(m_a);
          tick; tick;
          check("rnd_multi_early", MonDReg, old);
          tick;
          check("rnd_multi", MonDReg, m_d);
        end
      endcase
      check_flags("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
